// File: rtl/cdc_pulse_tx.sv
// Source side of a toggle-based pulse synchronizer: converts single-cycle
// requests into tx_tgl level changes, queues requests while an ack is pending.
module cdc_pulse_tx #(
    parameter int TIMEOUT  = 16,
    parameter int PEND_MAX = 3
) (
    input  logic                          clka,
    input  logic                          rst_n,
    input  logic                          req,
    input  logic                          ack_tgl,
    input  logic                          clr_err,
    output logic                          tx_tgl,
    output logic                          busy,
    output logic [$clog2(PEND_MAX+1)-1:0] pend_cnt,
    output logic                          ovf,
    output logic                          timeout_err
);
    localparam int PW = $clog2(PEND_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        ERR      = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ack_s1_q, ack_s2_q, ack_s3_q;
    logic          ack_edge;

    // ack_tgl is asynchronous: two flops for metastability, a third for edge history.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
            ack_s3_q <= 1'b0;
        end else begin
            ack_s1_q <= ack_tgl;
            ack_s2_q <= ack_s1_q;
            ack_s3_q <= ack_s2_q;
        end
    end

    assign ack_edge = ack_s2_q ^ ack_s3_q;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        pend_d  = pend_q;
        ovf_d   = 1'b0;
        err_d   = err_q;
        timer_d = timer_q;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (req) begin
                    tx_d    = ~tx_q;
                    state_d = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                timer_d = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + TW'(1);
                if (ack_edge) begin
                    // An ack beats a coincident timeout; req with a queued entry nets to zero.
                    if (pend_q != '0) begin
                        tx_d    = ~tx_q;
                        timer_d = '0;
                        if (!req)
                            pend_d = pend_q - PW'(1);
                    end else if (req) begin
                        tx_d    = ~tx_q;
                        timer_d = '0;
                    end else begin
                        state_d = IDLE;
                        timer_d = '0;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    pend_d  = '0;
                    timer_d = '0;
                    ovf_d   = req;
                end else if (req) begin
                    if (pend_q == PW'(PEND_MAX))
                        ovf_d = 1'b1;
                    else
                        pend_d = pend_q + PW'(1);
                end
            end

            ERR: begin
                timer_d = '0;
                pend_d  = '0;
                ovf_d   = req;
                if (clr_err) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
                pend_d  = '0;
            end
        endcase
    end

    // busy is registered from the next state so it never glitches.
    assign busy_d = (state_d != IDLE);

    assign tx_tgl      = tx_q;
    assign busy        = busy_q;
    assign pend_cnt    = pend_q;
    assign ovf         = ovf_q;
    assign timeout_err = err_q;

endmodule
